// File: rtl/ldi_pkg.sv
// Shared types for the LDI timing detector.
// Holds the FSM state encoding and the measured timing record.
package ldi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_VALID   = 2'd2
    } ldi_state_t;

    // Fields are wide enough for any counter width; narrower values
    // are zero-extended so records compare directly.
    typedef struct packed {
        logic [31:0] h_active;
        logic [31:0] h_total;
        logic [31:0] v_active;
        logic [31:0] v_total;
    } ldi_timing_t;

endpackage

// File: rtl/ldi_line_counter.sv
// Per-line beat and data-enable counter for the LDI timing detector.
// Ports: clock, reset (sync, active high), line_bnd (hsync falling edge),
// de (lane 0); line_done/line_total/line_width/line_sat report the line
// that ends at each boundary.
module ldi_line_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             line_bnd,
    input  logic             de,
    output logic             line_done,
    output logic [CNT_W-1:0] line_total,
    output logic [CNT_W-1:0] line_width,
    output logic             line_sat
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] de_cnt;

    // The boundary beat is the first beat of the new line, so the
    // counters restart at one (or at the beat's de) rather than zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt <= '0;
            de_cnt   <= '0;
        end else if (line_bnd) begin
            beat_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            de_cnt   <= {{(CNT_W-1){1'b0}}, de};
        end else begin
            if (beat_cnt != CMAX)
                beat_cnt <= beat_cnt + 1'b1;
            if (de && de_cnt != CMAX)
                de_cnt <= de_cnt + 1'b1;
        end
    end

    assign line_done  = line_bnd;
    assign line_total = beat_cnt;
    assign line_width = de_cnt;
    assign line_sat   = (beat_cnt == CMAX) || (de_cnt == CMAX);

endmodule

// File: rtl/ldi_timing_detector.sv
// LDI video timing detector: measures line/frame geometry from lane 0
// sync and data enable, and declares a mode once it is stable.
// Ports: clock, reset (sync, active high), in_locked, per-lane
// in_hsync_n/in_vsync_n/in_de; outputs h_active/h_total (pixels),
// v_active/v_total (lines), mode_valid, mode_changed, frame_start,
// lane_error (sticky).
module ldi_timing_detector
    import ldi_pkg::*;
#(
    parameter int pixels_in_parallel = 2,
    parameter int CNT_W              = 12,
    parameter int STABLE_FRAMES      = 4,
    parameter int TIMEOUT_CYCLES     = 2_000_000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_locked,
    input  logic [pixels_in_parallel-1:0] in_hsync_n,
    input  logic [pixels_in_parallel-1:0] in_vsync_n,
    input  logic [pixels_in_parallel-1:0] in_de,
    output logic [CNT_W:0]                h_active,
    output logic [CNT_W:0]                h_total,
    output logic [CNT_W-1:0]              v_active,
    output logic [CNT_W-1:0]              v_total,
    output logic                          mode_valid,
    output logic                          mode_changed,
    output logic                          frame_start,
    output logic                          lane_error
);

    localparam int SW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = CNT_W + 1;
    localparam logic [CNT_W-1:0] CMAX = '1;

    ldi_state_t state;

    logic prev_hs;
    logic prev_vs;
    logic frame_bnd;
    logic line_bnd;
    logic lane_mis;

    logic [TW-1:0] timer;
    logic          to_hit;

    logic             line_done;
    logic [CNT_W-1:0] line_total;
    logic [CNT_W-1:0] line_width;
    logic             line_sat;

    logic [CNT_W-1:0] f_total, n_total;
    logic [CNT_W-1:0] f_width, n_width;
    logic [CNT_W-1:0] f_lines, n_lines;
    logic [CNT_W-1:0] f_act, n_act;
    logic             f_have_t, n_have_t;
    logic             f_have_w, n_have_w;
    logic             f_bad, n_bad;

    logic [CNT_W:0] ht_pix;
    logic [CNT_W:0] ha_pix;
    ldi_timing_t    rec;
    ldi_timing_t    cand;
    ldi_timing_t    out_rec;
    logic           good;
    logic [SW-1:0]  stable_cnt;
    logic [SW-1:0]  next_stable;
    logic           discard;

    assign frame_bnd = prev_vs & ~in_vsync_n[0];
    assign line_bnd  = prev_hs & ~in_hsync_n[0];

    assign lane_mis =
        |(in_hsync_n ^ {pixels_in_parallel{in_hsync_n[0]}}) |
        |(in_vsync_n ^ {pixels_in_parallel{in_vsync_n[0]}}) |
        |(in_de      ^ {pixels_in_parallel{in_de[0]}});

    assign to_hit = (timer == TW'(TIMEOUT_CYCLES - 1));

    ldi_line_counter #(
        .CNT_W(CNT_W)
    ) u_line (
        .clock     (clock),
        .reset     (reset),
        .line_bnd  (line_bnd),
        .de        (in_de[0]),
        .line_done (line_done),
        .line_total(line_total),
        .line_width(line_width),
        .line_sat  (line_sat)
    );

    // A line event on the frame-boundary beat belongs to the new frame's
    // accumulators; the closing frame is judged from the registered
    // values, so both effects apply in the same cycle.
    always_comb begin
        n_total  = f_total;
        n_width  = f_width;
        n_lines  = f_lines;
        n_act    = f_act;
        n_have_t = f_have_t;
        n_have_w = f_have_w;
        n_bad    = f_bad;
        if (frame_bnd) begin
            n_total  = '0;
            n_width  = '0;
            n_lines  = '0;
            n_act    = '0;
            n_have_t = 1'b0;
            n_have_w = 1'b0;
            n_bad    = 1'b0;
        end
        if (line_done) begin
            if (!n_have_t) begin
                n_total  = line_total;
                n_have_t = 1'b1;
            end else if (line_total != n_total) begin
                n_bad = 1'b1;
            end
            if (line_width != '0) begin
                if (!n_have_w) begin
                    n_width  = line_width;
                    n_have_w = 1'b1;
                end else if (line_width != n_width) begin
                    n_bad = 1'b1;
                end
                if (n_act != CMAX)
                    n_act = n_act + 1'b1;
                if (n_act == CMAX)
                    n_bad = 1'b1;
            end
            if (n_lines != CMAX)
                n_lines = n_lines + 1'b1;
            if (n_lines == CMAX)
                n_bad = 1'b1;
            if (line_sat)
                n_bad = 1'b1;
        end
    end

    assign ht_pix = {1'b0, f_total} * PW'(pixels_in_parallel);
    assign ha_pix = {1'b0, f_width} * PW'(pixels_in_parallel);

    always_comb begin
        rec          = '0;
        rec.h_active = 32'(ha_pix);
        rec.h_total  = 32'(ht_pix);
        rec.v_active = 32'(f_act);
        rec.v_total  = 32'(f_lines);
        out_rec          = '0;
        out_rec.h_active = 32'(h_active);
        out_rec.h_total  = 32'(h_total);
        out_rec.v_active = 32'(v_active);
        out_rec.v_total  = 32'(v_total);
    end

    // A frame with no complete line has nothing to measure.
    assign good = ~f_bad & f_have_t;

    // A candidate left by a bad frame carries stable_cnt=0 and never
    // matches, so the next good frame starts a fresh count.
    always_comb begin
        next_stable = good ? SW'(1) : '0;
        if (good && stable_cnt != '0 && rec == cand)
            next_stable = stable_cnt + SW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_hs     <= 1'b0;
            prev_vs     <= 1'b0;
            lane_error  <= 1'b0;
            frame_start <= 1'b0;
            timer       <= '0;
            f_total     <= '0;
            f_width     <= '0;
            f_lines     <= '0;
            f_act       <= '0;
            f_have_t    <= 1'b0;
            f_have_w    <= 1'b0;
            f_bad       <= 1'b0;
        end else begin
            prev_hs     <= in_hsync_n[0];
            prev_vs     <= in_vsync_n[0];
            lane_error  <= lane_error | lane_mis;
            frame_start <= frame_bnd;
            timer       <= (frame_bnd || to_hit) ? '0 : timer + 1'b1;
            f_total     <= n_total;
            f_width     <= n_width;
            f_lines     <= n_lines;
            f_act       <= n_act;
            f_have_t    <= n_have_t;
            f_have_w    <= n_have_w;
            f_bad       <= n_bad;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            stable_cnt   <= '0;
            discard      <= 1'b0;
            cand         <= '0;
            mode_valid   <= 1'b0;
            mode_changed <= 1'b0;
            h_active     <= '0;
            h_total      <= '0;
            v_active     <= '0;
            v_total      <= '0;
        end else begin
            mode_changed <= 1'b0;
            if (!in_locked || to_hit) begin
                state      <= ST_IDLE;
                mode_valid <= 1'b0;
            end else if (frame_bnd) begin
                unique case (state)
                    ST_IDLE: begin
                        state      <= ST_ACQUIRE;
                        stable_cnt <= '0;
                        discard    <= 1'b1;
                    end
                    ST_ACQUIRE: begin
                        if (discard) begin
                            discard <= 1'b0;
                        end else begin
                            cand <= rec;
                            if (next_stable == SW'(STABLE_FRAMES)) begin
                                h_active     <= ha_pix;
                                h_total      <= ht_pix;
                                v_active     <= f_act;
                                v_total      <= f_lines;
                                mode_changed <= 1'b1;
                                mode_valid   <= 1'b1;
                                stable_cnt   <= '0;
                                state        <= ST_VALID;
                            end else begin
                                stable_cnt <= next_stable;
                            end
                        end
                    end
                    ST_VALID: begin
                        if (!good || rec != out_rec) begin
                            mode_valid <= 1'b0;
                            cand       <= rec;
                            stable_cnt <= good ? SW'(1) : '0;
                            state      <= ST_ACQUIRE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
